// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg - shared types and defaults for the data-memory port arbiter.
//   arb_state_e : arbiter FSM states (IDLE, CPU_OWN, EXT_OWN)
//   owner_e     : requester identity used for last_owner and read-return tag
//   DM_ARB_*    : default parameter values
//   owner_of()  : maps an owning state to its requester
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_OWN = 2'd1,
    EXT_OWN = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_EXT = 1'b1
  } owner_e;

  localparam int DM_ARB_DATA_W     = 16;
  localparam int DM_ARB_ADDR_W     = 8;
  localparam int DM_ARB_MAX_BURST  = 4;
  localparam int DM_ARB_PROT_LIMIT = 16;

  // Only meaningful for the two owning states; IDLE maps to CPU.
  function automatic owner_e owner_of(input arb_state_e st);
    owner_e own;
    case (st)
      EXT_OWN: own = OWN_EXT;
      CPU_OWN: own = OWN_CPU;
      default: own = OWN_CPU;
    endcase
    return own;
  endfunction

endpackage

// File: rtl/dm_arb_burst_ctr.sv
// dm_arb_burst_ctr - counts accesses made during one ownership period.
//   clk, rst  : clock, asynchronous active-low reset
//   clr       : clear the count (owner change / IDLE)
//   inc       : one access performed this cycle
//   limit_hit : this access is the MAX_BURST-th of the current run
// The count returns to zero on a limit hit, whether or not ownership moves,
// so an uncontested owner starts a fresh run of MAX_BURST accesses.
module dm_arb_burst_ctr #(
  parameter  int MAX_BURST = 4,
  localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic limit_hit
);

  logic [CNT_W-1:0] cnt_r;

  assign limit_hit = inc && (cnt_r == CNT_W'(MAX_BURST - 1));

  // Access counter: clear, wrap on limit, otherwise count accesses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (clr || limit_hit) begin
      cnt_r <= '0;
    end else if (inc) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter - shares one synchronous data memory between the CPU and
// an external loader/debug master.
//   clk, rst                         : clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata            : CPU request (held until served)
//   cpu_gnt/rdata/rvalid             : CPU access strobe and read return
//   ext_req/we/addr/wdata            : EXT request (held until served)
//   ext_gnt/rdata/rvalid             : EXT access strobe and read return
//   mem_en/we/addr/wdata, mem_rdata  : memory macro port (1-cycle read latency)
//   ext_err                          : only with DM_ARB_WR_PROTECT_EN; pulses the
//                                      cycle after a blocked EXT write below
//                                      PROT_LIMIT
// Round-robin on contention, forced handoff after MAX_BURST accesses while
// the other side waits, read data steered back by a registered tag.
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int DATA_W     = DM_ARB_DATA_W,
  parameter int ADDR_W     = DM_ARB_ADDR_W,
  parameter int MAX_BURST  = DM_ARB_MAX_BURST,
  parameter int PROT_LIMIT = DM_ARB_PROT_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DM_ARB_WR_PROTECT_EN
  ,
  output logic              ext_err
`endif
);

  arb_state_e        state_r, state_s;
  owner_e            last_owner_r;
  owner_e            tag_r;
  logic              pend_r;
  logic [DATA_W-1:0] cpu_rdata_r, ext_rdata_r;
  logic              acc_s, clr_s, limit_hit_s;
`ifdef DM_ARB_WR_PROTECT_EN
  logic              blk_s, err_r;
`endif

  dm_arb_burst_ctr #(.MAX_BURST(MAX_BURST)) u_burst_ctr (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr_s),
    .inc       (acc_s),
    .limit_hit (limit_hit_s)
  );

  // Next-state, grant and memory-port mux.
  always_comb begin
    state_s   = state_r;
    cpu_gnt   = 1'b0;
    ext_gnt   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    acc_s     = 1'b0;
    clr_s     = 1'b0;
`ifdef DM_ARB_WR_PROTECT_EN
    blk_s     = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        clr_s = 1'b1;
        if (cpu_req && ext_req) begin
          state_s = (last_owner_r == OWN_EXT) ? CPU_OWN : EXT_OWN;
        end else if (cpu_req) begin
          state_s = CPU_OWN;
        end else if (ext_req) begin
          state_s = EXT_OWN;
        end else begin
          state_s = IDLE;
        end
      end
      CPU_OWN: begin
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        if (cpu_req) begin
          cpu_gnt = 1'b1;
          mem_en  = 1'b1;
          acc_s   = 1'b1;
          if (limit_hit_s && ext_req) begin
            state_s = EXT_OWN;
            clr_s   = 1'b1;
          end else begin
            state_s = CPU_OWN;
          end
        end else begin
          clr_s   = 1'b1;
          state_s = ext_req ? EXT_OWN : IDLE;
        end
      end
      EXT_OWN: begin
        mem_we    = ext_we;
        mem_addr  = ext_addr;
        mem_wdata = ext_wdata;
        if (ext_req) begin
          ext_gnt = 1'b1;
          mem_en  = 1'b1;
          acc_s   = 1'b1;
`ifdef DM_ARB_WR_PROTECT_EN
          // Blocked writes are still granted and still consume burst budget.
          if (ext_we && (int'(ext_addr) < PROT_LIMIT)) begin
            blk_s  = 1'b1;
            mem_en = 1'b0;
            mem_we = 1'b0;
          end else begin
            blk_s  = 1'b0;
          end
`endif
          if (limit_hit_s && cpu_req) begin
            state_s = CPU_OWN;
            clr_s   = 1'b1;
          end else begin
            state_s = EXT_OWN;
          end
        end else begin
          clr_s   = 1'b1;
          state_s = cpu_req ? CPU_OWN : IDLE;
        end
      end
      default: begin
        state_s = IDLE;
        clr_s   = 1'b1;
      end
    endcase
  end

  // State register and round-robin history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      last_owner_r <= OWN_EXT;
    end else begin
      state_r <= state_s;
      if ((state_s != IDLE) && (state_s != state_r)) begin
        last_owner_r <= owner_of(state_s);
      end else begin
        last_owner_r <= last_owner_r;
      end
    end
  end

  // Read-return tag: remembers who issued the read so the data follows the
  // issuer even if ownership has already moved on.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_r <= 1'b0;
      tag_r  <= OWN_CPU;
    end else begin
      pend_r <= mem_en && !mem_we;
      tag_r  <= owner_of(state_r);
    end
  end

  // Per-side read data holding registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rdata_r <= '0;
      ext_rdata_r <= '0;
    end else begin
      if (cpu_rvalid) begin
        cpu_rdata_r <= mem_rdata;
      end else begin
        cpu_rdata_r <= cpu_rdata_r;
      end
      if (ext_rvalid) begin
        ext_rdata_r <= mem_rdata;
      end else begin
        ext_rdata_r <= ext_rdata_r;
      end
    end
  end

  assign cpu_rvalid = pend_r && (tag_r == OWN_CPU);
  assign ext_rvalid = pend_r && (tag_r == OWN_EXT);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_r;
  assign ext_rdata  = ext_rvalid ? mem_rdata : ext_rdata_r;

`ifdef DM_ARB_WR_PROTECT_EN
  // One-cycle error pulse following a blocked EXT write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_r <= 1'b0;
    end else begin
      err_r <= blk_s;
    end
  end

  assign ext_err = err_r;
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter - directed bench for dm_port_arbiter with a behavioural
// single-port memory (1-cycle read latency). Inputs change 1 time unit after
// the rising edge, outputs are checked 1 time unit later.
// Optional protect feature is exercised when DM_ARB_WR_PROTECT_EN is defined.
module tb_dm_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [7:0]  cpu_addr = 8'h00;
  logic [15:0] cpu_wdata = 16'h0000;
  logic        cpu_gnt, cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic        ext_req = 1'b0, ext_we = 1'b0;
  logic [7:0]  ext_addr = 8'h00;
  logic [15:0] ext_wdata = 16'h0000;
  logic        ext_gnt, ext_rvalid;
  logic [15:0] ext_rdata;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0000;
`ifdef DM_ARB_WR_PROTECT_EN
  logic        ext_err;
`endif

  logic [15:0] mem [0:255];
  int          checks_n = 0;
  int          fails_n  = 0;

  dm_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .ext_req    (ext_req),
    .ext_we     (ext_we),
    .ext_addr   (ext_addr),
    .ext_wdata  (ext_wdata),
    .ext_gnt    (ext_gnt),
    .ext_rdata  (ext_rdata),
    .ext_rvalid (ext_rvalid),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
`ifdef DM_ARB_WR_PROTECT_EN
    ,
    .ext_err    (ext_err)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural synchronous memory.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_n++;
    assert (obs === exp)
    else begin
      fails_n++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

    // Reset state
    #1 rst = 1'b0;
    #1;
    chk("rst_cpu_gnt", cpu_gnt, 1'b0);
    chk("rst_ext_gnt", ext_gnt, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 8'h00);
    chk("rst_cpu_rvalid", cpu_rvalid, 1'b0);
    chk("rst_cpu_rdata", cpu_rdata, 16'h0000);
    @(negedge clk) rst = 1'b1;
    tick();

    // Simultaneous first requests: CPU first, then EXT without IDLE
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h01; cpu_wdata = 16'h1111;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 8'h02; ext_wdata = 16'h2222;
    #1;
    chk("sim_idle_cpu_gnt", cpu_gnt, 1'b0);
    chk("sim_idle_ext_gnt", ext_gnt, 1'b0);
    tick();
    chk("sim_cpu_first", cpu_gnt, 1'b1);
    chk("sim_ext_wait", ext_gnt, 1'b0);
    chk("sim_cpu_addr", mem_addr, 8'h01);
    tick();
    cpu_req = 1'b0;
    #1;
    chk("sim_switch_no_access", mem_en, 1'b0);
    tick();
    chk("sim_ext_gnt", ext_gnt, 1'b1);
    chk("sim_ext_addr", mem_addr, 8'h02);
    chk("sim_ext_wdata", mem_wdata, 16'h2222);
    tick();
    ext_req = 1'b0;
    tick();
    chk("sim_idle_again", ext_gnt, 1'b0);
    chk("sim_mem1", mem[1], 16'h1111);

    // Single CPU write then read
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h05; cpu_wdata = 16'h1234;
    #1;
    chk("wr_gnt_latency", cpu_gnt, 1'b0);
    tick();
    chk("wr_gnt", cpu_gnt, 1'b1);
    chk("wr_mem_we", mem_we, 1'b1);
    chk("wr_mem_addr", mem_addr, 8'h05);
    chk("wr_mem_wdata", mem_wdata, 16'h1234);
    tick();
    cpu_we = 1'b0;
    #1;
    chk("rd_gnt", cpu_gnt, 1'b1);
    chk("rd_mem_we", mem_we, 1'b0);
    chk("rd_no_rvalid_after_wr", cpu_rvalid, 1'b0);
    tick();
    cpu_req = 1'b0;
    #1;
    chk("rd_rvalid", cpu_rvalid, 1'b1);
    chk("rd_rdata", cpu_rdata, 16'h1234);
    chk("rd_ext_rvalid", ext_rvalid, 1'b0);
    tick();
    chk("rd_rvalid_pulse", cpu_rvalid, 1'b0);
    chk("rd_rdata_hold", cpu_rdata, 16'h1234);

    // Burst limit with read across handoff
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 16'hBEEF;
    tick();
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 8'h30; ext_wdata = 16'h3030;
    #1;
    chk("bl_cpu1", cpu_gnt, 1'b1);
    chk("bl_ext_wait1", ext_gnt, 1'b0);
    tick();
    chk("bl_cpu2", cpu_gnt, 1'b1);
    tick();
    chk("bl_cpu3", cpu_gnt, 1'b1);
    tick();
    cpu_we = 1'b0;
    #1;
    chk("bl_cpu4_read", cpu_gnt, 1'b1);
    chk("bl_ext_wait4", ext_gnt, 1'b0);
    tick();
    chk("ho_ext_gnt", ext_gnt, 1'b1);
    chk("ho_cpu_gnt", cpu_gnt, 1'b0);
    chk("ho_cpu_rvalid", cpu_rvalid, 1'b1);
    chk("ho_cpu_rdata", cpu_rdata, 16'hBEEF);
    chk("ho_ext_rvalid", ext_rvalid, 1'b0);
    chk("ho_mem_addr", mem_addr, 8'h30);
    tick();
    chk("bl_ext2", ext_gnt, 1'b1);
    chk("ho_rvalid_done", cpu_rvalid, 1'b0);
    tick();
    chk("bl_ext3", ext_gnt, 1'b1);
    tick();
    chk("bl_ext4", ext_gnt, 1'b1);
    chk("bl_cpu_wait", cpu_gnt, 1'b0);
    tick();
    ext_req = 1'b0;
    #1;
    chk("bl_back_to_cpu", cpu_gnt, 1'b1);
    chk("bl_ext_off", ext_gnt, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("run10_cpu_%0d", i), cpu_gnt, 1'b1);
      tick();
    end
    cpu_req = 1'b0;
    tick();
    chk("run10_idle", cpu_gnt, 1'b0);
    chk("mem30", mem[8'h30], 16'h3030);

    // Async reset with an EXT read pending
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 8'h30;
    tick();
    chk("ar_ext_gnt", ext_gnt, 1'b1);
    tick();
    chk("ar_ext_rvalid", ext_rvalid, 1'b1);
    chk("ar_ext_rdata", ext_rdata, 16'h3030);
    #1 rst = 1'b0;
    #1;
    chk("ar_rvalid_cut", ext_rvalid, 1'b0);
    chk("ar_gnt_cut", ext_gnt, 1'b0);
    chk("ar_mem_en_cut", mem_en, 1'b0);
    chk("ar_ext_rdata_cut", ext_rdata, 16'h0000);
    chk("ar_cpu_rdata_cut", cpu_rdata, 16'h0000);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h40; cpu_wdata = 16'h4444;
    @(negedge clk) rst = 1'b1;
    tick();
    chk("ar_cpu_first", cpu_gnt, 1'b1);
    chk("ar_ext_second", ext_gnt, 1'b0);
    chk("ar_no_rvalid", ext_rvalid, 1'b0);
    cpu_req = 1'b0; ext_req = 1'b0;
    tick();

`ifdef DM_ARB_WR_PROTECT_EN
    // Protected EXT write is granted but blocked
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 8'h03; ext_wdata = 16'hDEAD;
    tick();
    chk("wp_gnt", ext_gnt, 1'b1);
    chk("wp_mem_en", mem_en, 1'b0);
    chk("wp_mem_we", mem_we, 1'b0);
    chk("wp_err_not_yet", ext_err, 1'b0);
    tick();
    ext_addr = 8'h20; ext_wdata = 16'hCAFE;
    #1;
    chk("wp_err_pulse", ext_err, 1'b1);
    chk("wp_ok_mem_en", mem_en, 1'b1);
    chk("wp_ok_mem_we", mem_we, 1'b1);
    tick();
    ext_req = 1'b0;
    #1;
    chk("wp_err_clear", ext_err, 1'b0);
    tick();
    chk("wp_mem3_unchanged", mem[3], 16'h0000);
    chk("wp_mem20", mem[8'h20], 16'hCAFE);
`else
    // Without protection a low-address EXT write lands normally
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 8'h03; ext_wdata = 16'hDEAD;
    tick();
    chk("np_gnt", ext_gnt, 1'b1);
    chk("np_mem_en", mem_en, 1'b1);
    chk("np_mem_we", mem_we, 1'b1);
    tick();
    ext_req = 1'b0;
    tick();
    chk("np_mem3", mem[3], 16'hDEAD);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks_n, fails_n);
    $finish;
  end

endmodule
